// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, ALU op select and bus timeouts.
// Optional macro ILLEGAL_TRAP_EN: an unsupported instruction parks the FSM in TRAP until reset.
module mips_mc_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter int unsigned TO_W           = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic        imm_zext,
   output logic        reg_dst_rd,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        bus_err,
   output logic        illegal
);

   // Handshake: a req stays high every cycle of its state until the matching ack is seen in that
   // same cycle; an ack arriving in any other state is ignored.

   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8;
   localparam logic [3:0] ALU_SRA = 4'd9;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   typedef enum logic [3:0] {
      C_ILL, C_RALU, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J
   } cls_t;

   state_t          state_q, state_d;
   logic [5:0]      opcode_q, funct_q;
   logic [3:0]      alu_ctrl_q;
   logic            illegal_q;
   logic [TO_W-1:0] to_cnt_q;

   cls_t            cls;
   logic [3:0]      dec_alu;
   logic            dec_zext, dec_imm, dec_rd;
   logic            req_wait, ack_now, expired;
   logic            unused_instr;

   assign unused_instr = ^instr[25:6];

   always_comb begin
      cls      = C_ILL;
      dec_alu  = ALU_NOP;
      dec_zext = 1'b0;
      case (opcode_q)
         6'h00: begin
            case (funct_q)
               6'h20, 6'h21: begin cls = C_RALU; dec_alu = ALU_ADD; end
               6'h22, 6'h23: begin cls = C_RALU; dec_alu = ALU_SUB; end
               6'h24:        begin cls = C_RALU; dec_alu = ALU_AND; end
               6'h25:        begin cls = C_RALU; dec_alu = ALU_OR;  end
               6'h27:        begin cls = C_RALU; dec_alu = ALU_NOR; end
               6'h2A:        begin cls = C_RALU; dec_alu = ALU_SLT; end
               6'h00:        begin cls = C_RALU; dec_alu = ALU_SLL; end
               6'h02:        begin cls = C_RALU; dec_alu = ALU_SRL; end
               6'h03:        begin cls = C_RALU; dec_alu = ALU_SRA; end
               6'h08:        cls = C_JR;
               default:      cls = C_ILL;
            endcase
         end
         6'h08, 6'h09: begin cls = C_IALU; dec_alu = ALU_ADD; end
         6'h0A:        begin cls = C_IALU; dec_alu = ALU_SLT; end
         6'h0C:        begin cls = C_IALU; dec_alu = ALU_AND; dec_zext = 1'b1; end
         6'h0D:        begin cls = C_IALU; dec_alu = ALU_OR;  dec_zext = 1'b1; end
         6'h23:        begin cls = C_LW;   dec_alu = ALU_ADD; end
         6'h2B:        begin cls = C_SW;   dec_alu = ALU_ADD; end
         6'h04:        begin cls = C_BEQ;  dec_alu = ALU_SUB; end
         6'h05:        begin cls = C_BNE;  dec_alu = ALU_SUB; end
         6'h02:        cls = C_J;
         default:      cls = C_ILL;
      endcase
   end

   assign dec_imm = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
   assign dec_rd  = (cls == C_RALU);

   // An ack in the expiry cycle still completes the transfer, so expiry requires no ack.
   always_comb begin
      req_wait = (state_q == S_FETCH) || (state_q == S_MEM);
      ack_now  = ((state_q == S_FETCH) && imem_ack) || ((state_q == S_MEM) && dmem_ack);
      expired  = (TIMEOUT_CYCLES != 0) && req_wait && !ack_now &&
                 (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
   end

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      alu_src_imm = 1'b0;
      imm_zext    = 1'b0;
      reg_dst_rd  = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      bus_err     = 1'b0;
      if (!rst) begin
         if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            alu_src_imm = dec_imm;
            imm_zext    = dec_zext;
            reg_dst_rd  = dec_rd;
         end
         case (state_q)
            S_FETCH: begin
               imem_req = !expired;
               if (imem_ack) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (expired) begin
                  bus_err = 1'b1;
               end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
               case (cls)
                  C_RALU, C_IALU: state_d = S_WB;
                  C_LW, C_SW:     state_d = S_MEM;
                  C_JR: begin
                     pc_write = 1'b1;
                     pc_src   = 2'b11;
                     state_d  = S_FETCH;
                  end
                  C_BEQ, C_BNE: begin
                     pc_write = (cls == C_BEQ) ? zero : !zero;
                     pc_src   = 2'b01;
                     state_d  = S_FETCH;
                  end
                  C_J: begin
                     pc_write = 1'b1;
                     pc_src   = 2'b10;
                     state_d  = S_FETCH;
                  end
`ifdef ILLEGAL_TRAP_EN
                  default: state_d = S_TRAP;
`else
                  default: state_d = S_FETCH;
`endif
               endcase
            end
            S_MEM: begin
               dmem_req = !expired;
               dmem_we  = !expired && (cls == C_SW);
               if (dmem_ack) begin
                  state_d = (cls == C_LW) ? S_WB : S_FETCH;
               end else if (expired) begin
                  bus_err = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls == C_LW);
               state_d    = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         opcode_q   <= 6'd0;
         funct_q    <= 6'd0;
         alu_ctrl_q <= ALU_NOP;
         illegal_q  <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_FETCH) && imem_ack) begin
            opcode_q <= instr[31:26];
            funct_q  <= instr[5:0];
         end
         // alu_ctrl is loaded on the DECODE->EXEC edge and held until the next EXEC entry.
         if (state_q == S_DECODE) begin
            alu_ctrl_q <= dec_alu;
            illegal_q  <= (cls == C_ILL);
         end
`ifndef ILLEGAL_TRAP_EN
         else if (state_q == S_EXEC) begin
            illegal_q <= 1'b0;
         end
`endif
         if ((TIMEOUT_CYCLES == 0) || (state_d != state_q) || expired) begin
            to_cnt_q <= '0;
         end else if (req_wait) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end
      end
   end

   assign alu_ctrl = alu_ctrl_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven bench for mips_mc_ctrl: instruction vectors plus hand-written
// timeout, reset and illegal-instruction sequences.
module tb_mips_mc_ctrl;

   localparam int K_WB  = 0;
   localparam int K_LW  = 1;
   localparam int K_SW  = 2;
   localparam int K_PC  = 3;
   localparam int K_ILL = 4;

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      logic [3:0]  alu;
      logic        imm;
      logic        zext;
      logic        rd;
      logic        pcw;
      logic [1:0]  pcsrc;
      int          kind;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        zero, imem_ack, dmem_ack;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic [3:0]  alu_ctrl;
   logic        alu_src_imm, imm_zext, reg_dst_rd, mem_to_reg, reg_write, bus_err, illegal;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mips_mc_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .imm_zext(imm_zext),
      .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .bus_err(bus_err), .illegal(illegal)
   );

   function automatic vec_t mk(input logic [31:0] i, input logic z, input logic [3:0] a,
                               input logic imm, input logic zx, input logic rd,
                               input logic pcw, input logic [1:0] ps, input int k);
      vec_t v;
      v.instr = i; v.zero = z; v.alu = a; v.imm = imm; v.zext = zx;
      v.rd = rd; v.pcw = pcw; v.pcsrc = ps; v.kind = k;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic tick(input logic ia, input logic da);
      @(negedge clk);
      imem_ack = ia;
      dmem_ack = da;
      #1;
   endtask

   task automatic run_front(input vec_t v, input int waits);
      instr = v.instr;
      zero  = v.zero;
      for (int w = 0; w < waits; w++) begin
         tick(1'b0, 1'b0);
         chk("fetch_req", imem_req, 1);
         chk("fetch_irw", ir_write, 0);
         chk("fetch_pcw", pc_write, 0);
         chk("fetch_regw", reg_write, 0);
         chk("fetch_ill", illegal, 0);
         chk("fetch_berr", bus_err, 0);
      end
      tick(1'b1, 1'b0);
      chk("ack_irw", ir_write, 1);
      chk("ack_pcw", pc_write, 1);
      chk("ack_pcsrc", pc_src, 0);
      chk("ack_berr", bus_err, 0);
      tick(1'b1, 1'b1);
      chk("dec_irw", ir_write, 0);
      chk("dec_pcw", pc_write, 0);
      chk("dec_imem_req", imem_req, 0);
      chk("dec_dmem_req", dmem_req, 0);
      tick(1'b0, 1'b0);
      chk("exec_alu", alu_ctrl, v.alu);
      chk("exec_imm", alu_src_imm, v.imm);
      chk("exec_zext", imm_zext, v.zext);
      chk("exec_rd", reg_dst_rd, v.rd);
      chk("exec_pcw", pc_write, v.pcw);
      chk("exec_pcsrc", pc_src, v.pcsrc);
      chk("exec_ill", illegal, (v.kind == K_ILL) ? 1 : 0);
      chk("exec_regw", reg_write, 0);
      chk("exec_dmem_req", dmem_req, 0);
   endtask

   task automatic run_vec(input vec_t v, input int waits);
      run_front(v, waits);
      if (v.kind == K_LW || v.kind == K_SW) begin
         tick(1'b1, 1'b0);
         chk("mem_req", dmem_req, 1);
         chk("mem_we", dmem_we, (v.kind == K_SW) ? 1 : 0);
         chk("mem_imm", alu_src_imm, 1);
         chk("mem_regw", reg_write, 0);
         tick(1'b0, 1'b1);
         chk("mem_ack_req", dmem_req, 1);
         chk("mem_ack_we", dmem_we, (v.kind == K_SW) ? 1 : 0);
      end
      if (v.kind == K_WB || v.kind == K_LW) begin
         tick(1'b0, 1'b0);
         chk("wb_regw", reg_write, 1);
         chk("wb_m2r", mem_to_reg, (v.kind == K_LW) ? 1 : 0);
         chk("wb_rd", reg_dst_rd, v.rd);
         chk("wb_imm", alu_src_imm, v.imm);
         chk("wb_alu", alu_ctrl, v.alu);
      end
   endtask

   initial begin
      vec_t add_v, lw_v, sw_v, ill_v;
      rst = 1'b1; instr = 32'd0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

      add_v = mk(32'h012A4020, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB);
      lw_v  = mk(32'h8D280004, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K_LW);
      sw_v  = mk(32'hAD280004, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K_SW);
      ill_v = mk(32'hFC000000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, K_ILL);

      tbl.push_back(add_v);
      tbl.push_back(mk(32'h012A4022, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h012A4024, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h012A4025, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h012A4027, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h012A402A, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h00094080, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h00094082, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h00094083, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h03E00008, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, K_PC));
      tbl.push_back(mk(32'h21280005, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h25280005, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h29280005, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h3128FFFF, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, K_WB));
      tbl.push_back(mk(32'h3528FFFF, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, K_WB));
      tbl.push_back(lw_v);
      tbl.push_back(sw_v);
      tbl.push_back(mk(32'h11280003, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, K_PC));
      tbl.push_back(mk(32'h11280003, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, K_PC));
      tbl.push_back(mk(32'h15280003, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, K_PC));
      tbl.push_back(mk(32'h15280003, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, K_PC));
      tbl.push_back(mk(32'h08000010, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, K_PC));
`ifndef ILLEGAL_TRAP_EN
      tbl.push_back(ill_v);
      tbl.push_back(mk(32'h00000001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, K_ILL));
`endif
      tbl.push_back(add_v);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_alu", alu_ctrl, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_irw", ir_write, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_imem_req", imem_req, 1);
      chk("rel_alu", alu_ctrl, 0);
      chk("rel_ill", illegal, 0);

      foreach (tbl[i]) run_vec(tbl[i], (i == 0) ? 2 : 1 + (i % 3));

      // Fetch timeout: 15 silent cycles, bus_err on the 16th, then ack exactly at the limit
      instr = add_v.instr;
      for (int c = 0; c < 15; c++) begin
         tick(1'b0, 1'b0);
         chk("to_wait_req", imem_req, 1);
         chk("to_wait_berr", bus_err, 0);
         chk("to_wait_pcw", pc_write, 0);
      end
      tick(1'b0, 1'b0);
      chk("to_berr", bus_err, 1);
      chk("to_req_drop", imem_req, 0);
      chk("to_pcw", pc_write, 0);
      chk("to_irw", ir_write, 0);
      run_vec(add_v, 15);

      // Data timeout on lw: no write-back, back to fetch
      run_front(lw_v, 1);
      for (int c = 0; c < 15; c++) begin
         tick(1'b1, 1'b0);
         chk("dto_wait_req", dmem_req, 1);
         chk("dto_wait_berr", bus_err, 0);
      end
      tick(1'b0, 1'b0);
      chk("dto_berr", bus_err, 1);
      chk("dto_req_drop", dmem_req, 0);
      chk("dto_regw", reg_write, 0);
      run_vec(sw_v, 1);

      // Asynchronous reset in the middle of a lw MEM phase
      run_front(lw_v, 2);
      tick(1'b0, 1'b0);
      chk("mrst_pre_req", dmem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_dmem_req", dmem_req, 0);
      chk("mrst_imem_req", imem_req, 0);
      chk("mrst_alu", alu_ctrl, 0);
      chk("mrst_imm", alu_src_imm, 0);
      chk("mrst_regw", reg_write, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_rel_req", imem_req, 1);
      chk("mrst_rel_alu", alu_ctrl, 0);
      chk("mrst_rel_ill", illegal, 0);
      run_vec(add_v, 1);

`ifdef ILLEGAL_TRAP_EN
      run_front(ill_v, 1);
      for (int c = 0; c < 4; c++) begin
         tick(1'b1, 1'b1);
         chk("trap_ill", illegal, 1);
         chk("trap_req", imem_req, 0);
         chk("trap_alu", alu_ctrl, 0);
         chk("trap_irw", ir_write, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("trap_rel_ill", illegal, 0);
      chk("trap_rel_req", imem_req, 1);
`else
      run_vec(ill_v, 1);
`endif
      tick(1'b0, 1'b0);
      chk("end_req", imem_req, 1);
      chk("end_regw", reg_write, 0);
      chk("end_ill", illegal, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
